// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate decode stage.
package imm_pkg;

    localparam int XLEN32 = 32;
    localparam int XLEN64 = 64;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_NONE = 3'b011,
        IMM_J    = 3'b100,
        IMM_U    = 3'b101,
        IMM_Z    = 3'b110,
        IMM_SH   = 3'b111
    } imm_src_e;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_PARTIAL = 2'b01,
        ST_FULL    = 2'b10
    } fifo_state_e;

endpackage

// File: rtl/imm_expand.sv
// Combinational immediate expander: maps an instruction word and format
// select to an XLEN-wide immediate.
module imm_expand
    import imm_pkg::*;
#(
    parameter int XLEN = XLEN32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm
);

    // Opcode bits play no part in immediate generation.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm = '0;
        case (imm_src)
            IMM_I:    imm = XLEN'($signed(instr[31:20]));
            IMM_S:    imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_B:    imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                           instr[11:8], 1'b0}));
            IMM_NONE: imm = '0;
            IMM_J:    imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                           instr[30:21], 1'b0}));
            IMM_U:    imm = XLEN'($signed({instr[31:12], 12'b0}));
            IMM_Z:    imm = XLEN'(instr[19:15]);
            IMM_SH:   imm = (XLEN == XLEN64) ? XLEN'(instr[25:20])
                                             : XLEN'(instr[24:20]);
            default:  imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate decode stage: expands the immediate, adds it to the
// PC, and buffers {imm, target, tag} in a small FIFO towards execute.
//
// state      | meaning
// ST_EMPTY   | no buffered entries, out_valid low
// ST_PARTIAL | 1..DEPTH-1 entries buffered
// ST_FULL    | DEPTH entries buffered, in_ready low
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = XLEN32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       ImmSrc,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_target,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  target;
    logic             push;
    logic             pop;

    logic [XLEN-1:0]  imm_q    [DEPTH];
    logic [XLEN-1:0]  imm_d    [DEPTH];
    logic [XLEN-1:0]  target_q [DEPTH];
    logic [XLEN-1:0]  target_d [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [TAG_W-1:0] tag_d    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fifo_state_e      state_q, state_d;

    imm_expand #(.XLEN(XLEN)) u_expand (
        .instr   (instr),
        .imm_src (ImmSrc),
        .imm     (imm)
    );

    assign target = in_pc + imm;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_imm    = imm_q[rd_ptr_q];
    assign out_target = target_q[rd_ptr_q];
    assign out_tag    = tag_q[rd_ptr_q];

    always_comb begin
        imm_d    = imm_q;
        target_d = target_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Flush wins over any same-cycle push or pop; stored data is left as is.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                imm_d[wr_ptr_q]    = imm;
                target_d[wr_ptr_q] = target;
                tag_d[wr_ptr_q]    = in_tag;
                wr_ptr_d           = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        if (count_d == '0) begin
            state_d = ST_EMPTY;
        end else if (count_d == CNT_FULL) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_PARTIAL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_EMPTY;
            for (int i = 0; i < DEPTH; i++) begin
                imm_q[i]    <= '0;
                target_q[i] <= '0;
                tag_q[i]    <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            imm_q    <= imm_d;
            target_q <= target_d;
            tag_q    <= tag_d;
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances driven in
// lockstep and compared against a queue-based reference model.
module tb_imm_decode_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic [63:0] in_pc;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_ready;
    logic [31:0] pc32;

    logic        rdy32, vld32, rdy64, vld64;
    logic [31:0] imm32, tgt32;
    logic [63:0] imm64, tgt64;
    logic [4:0]  tag32, tag64;

    assign pc32 = in_pc[31:0];

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(5)) dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (rdy32),
        .instr      (instr),
        .ImmSrc     (imm_src),
        .in_pc      (pc32),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (vld32),
        .out_ready  (out_ready),
        .out_imm    (imm32),
        .out_target (tgt32),
        .out_tag    (tag32)
    );

    imm_decode_stage #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(5)) dut64 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (rdy64),
        .instr      (instr),
        .ImmSrc     (imm_src),
        .in_pc      (in_pc),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (vld64),
        .out_ready  (out_ready),
        .out_imm    (imm64),
        .out_target (tgt64),
        .out_tag    (tag64)
    );

    typedef struct {
        bit [63:0] imm32;
        bit [63:0] tgt32;
        bit [63:0] imm64;
        bit [63:0] tgt64;
        bit [4:0]  tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Immediate from field arithmetic on sign-extended 64-bit integers.
    function automatic bit [63:0] ref_imm(bit [31:0] w, bit [2:0] src, int xlen);
        longint s;
        longint lw;
        longint v;
        s  = longint'($signed(w));
        lw = longint'({32'b0, w});
        case (src)
            3'd0:    v = s >>> 20;
            3'd1:    v = ((s >>> 25) <<< 5) | ((lw >> 7) & 31);
            3'd2:    v = ((s >>> 31) <<< 12) | (((lw >> 7) & 1) << 11)
                       | (((lw >> 25) & 63) << 5) | (((lw >> 8) & 15) << 1);
            3'd3:    v = 0;
            3'd4:    v = ((s >>> 31) <<< 20) | (((lw >> 12) & 255) << 12)
                       | (((lw >> 20) & 1) << 11) | (((lw >> 21) & 1023) << 1);
            3'd5:    v = (s >>> 12) <<< 12;
            3'd6:    v = (lw >> 15) & 31;
            default: v = (xlen == 32) ? ((lw >> 20) & 31) : ((lw >> 20) & 63);
        endcase
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        return 64'(v);
    endfunction

    task automatic compare_all();
        check("valid32", vld32, 64'(q.size() != 0));
        check("valid64", vld64, 64'(q.size() != 0));
        check("ready32", rdy32, 64'(q.size() < DEPTH));
        check("ready64", rdy64, 64'(q.size() < DEPTH));
        if (q.size() != 0) begin
            check("imm32", imm32, q[0].imm32);
            check("tgt32", tgt32, q[0].tgt32);
            check("tag32", tag32, q[0].tag);
            check("imm64", imm64, q[0].imm64);
            check("tgt64", tgt64, q[0].tgt64);
            check("tag64", tag64, q[0].tag);
        end
    endtask

    // Called just after a falling edge: drive, update the model, clock, check.
    task automatic step(bit v, bit [31:0] w, bit [2:0] src, bit [63:0] pc,
                        bit [4:0] tg, bit fl, bit ordy);
        exp_t e;
        bit   do_push;
        bit   do_pop;
        in_valid  = v;
        instr     = w;
        imm_src   = src;
        in_pc     = pc;
        in_tag    = tg;
        flush     = fl;
        out_ready = ordy;
        do_push = v && (q.size() < DEPTH);
        do_pop  = ordy && (q.size() > 0);
        e.imm32 = ref_imm(w, src, 32);
        e.tgt32 = (pc + e.imm32) & 64'hFFFF_FFFF;
        e.imm64 = ref_imm(w, src, 64);
        e.tgt64 = pc + e.imm64;
        e.tag   = tg;
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) q.delete(0);
            if (do_push) q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 3'd0, 64'h0, 5'd0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        imm_src   = '0;
        in_pc     = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        @(negedge clk);
        check("rst_valid32", vld32, 64'd0);
        check("rst_ready32", rdy32, 64'd1);
        check("rst_imm32",   imm32, 64'd0);
        check("rst_tgt32",   tgt32, 64'd0);
        check("rst_tag32",   tag32, 64'd0);
        check("rst_valid64", vld64, 64'd0);
        check("rst_ready64", rdy64, 64'd1);
        check("rst_imm64",   imm64, 64'd0);
        check("rst_tgt64",   tgt64, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Format examples
        step(1'b1, 32'hFFF0_0093, 3'd0, 64'h0, 5'd1, 1'b0, 1'b0);
        check("i_imm32", imm32, 64'hFFFF_FFFF);
        check("i_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        idle();
        step(1'b1, 32'hFE00_0EE3, 3'd2, 64'h100, 5'd2, 1'b0, 1'b0);
        check("b_imm32", imm32, 64'hFFFF_FFFC);
        check("b_tgt32", tgt32, 64'h0000_00FC);
        idle();
        step(1'b1, 32'h0080_006F, 3'd4, 64'h200, 5'd3, 1'b0, 1'b0);
        check("j_imm32", imm32, 64'h8);
        check("j_tgt32", tgt32, 64'h208);
        idle();
        step(1'b1, 32'h8000_00B7, 3'd5, 64'h0, 5'd4, 1'b0, 1'b0);
        check("u_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        idle();
        step(1'b1, 32'h000F_8073, 3'd6, 64'h0, 5'd5, 1'b0, 1'b0);
        check("z_imm32", imm32, 64'h1F);
        check("z_imm64", imm64, 64'h1F);
        idle();
        step(1'b1, 32'h03F0_0013, 3'd7, 64'h0, 5'd6, 1'b0, 1'b0);
        check("sh_imm64", imm64, 64'h3F);
        check("sh_imm32", imm32, 64'h1F);
        idle();

        // Fill, hold off the third word, then drain in order
        step(1'b1, 32'h0, 3'd0, 64'h0, 5'd1, 1'b0, 1'b0);
        step(1'b1, 32'h0, 3'd0, 64'h0, 5'd2, 1'b0, 1'b0);
        check("full_ready32", rdy32, 64'd0);
        check("full_ready64", rdy64, 64'd0);
        step(1'b1, 32'h0, 3'd0, 64'h0, 5'd3, 1'b0, 1'b0);
        check("held_head", tag32, 64'd1);
        step(1'b1, 32'h0, 3'd0, 64'h0, 5'd3, 1'b0, 1'b1);
        check("order_2", tag32, 64'd2);
        step(1'b1, 32'h0, 3'd0, 64'h0, 5'd3, 1'b0, 1'b1);
        check("order_3", tag64, 64'd3);
        idle();
        check("drained", vld32, 64'd0);

        // Flush with a same-cycle push
        step(1'b1, 32'h0, 3'd0, 64'h0, 5'd7, 1'b0, 1'b0);
        step(1'b1, 32'h0, 3'd0, 64'h0, 5'd8, 1'b0, 1'b0);
        step(1'b1, 32'h0, 3'd0, 64'h0, 5'd9, 1'b1, 1'b1);
        check("flush_valid", vld32, 64'd0);
        check("flush_ready", rdy32, 64'd1);
        idle();
        check("flush_gone", vld64, 64'd0);

        // Asynchronous reset with one entry buffered
        step(1'b1, 32'hFFF0_0093, 3'd0, 64'h40, 5'd10, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid32", vld32, 64'd0);
        check("arst_imm32",   imm32, 64'd0);
        check("arst_valid64", vld64, 64'd0);
        check("arst_imm64",   imm64, 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();

        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom, 3'($urandom_range(7, 0)),
                 {$urandom, $urandom}, 5'($urandom), ($urandom % 32) == 0,
                 ($urandom % 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
